// File: rtl/des_pkg.sv
// Shared DES key-schedule constants, types and helpers (PC-1/PC-2 tables, shift schedules).
package des_pkg;

  typedef logic [47:0] des_subkey_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } ks_state_e;

  // Table entries use DES bit numbering: bit 1 is the MSB of the source vector.
  localparam int unsigned PC1_TABLE [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2_TABLE [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  localparam int unsigned SHIFT_ENC [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam int unsigned SHIFT_DEC [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int unsigned i = 0; i < 56; i++) begin
      r[6'(55 - i)] = k[6'(64 - PC1_TABLE[i])];
    end
    return r;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input int unsigned n);
    return (x << n) | (x >> (28 - n));
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input int unsigned n);
    return (x >> n) | (x << (28 - n));
  endfunction

  function automatic logic key_parity_ok(input logic [63:0] k);
    logic        ok;
    logic [63:0] t;
    ok = 1'b1;
    t  = k;
    for (int unsigned b = 0; b < 8; b++) begin
      ok = ok & (^t[7:0]);
      t  = t >> 8;
    end
    return ok;
  endfunction

endpackage

// File: rtl/des_key_schedule_if.sv
// Subkey delivery channel: valid/ready stream of 48-bit round subkeys with their delivery index.
interface des_key_schedule_if;
  import des_pkg::*;

  des_subkey_t subkey;
  logic        subkey_valid;
  logic        subkey_ready;
  logic [3:0]  round_idx;

  modport master (output subkey, output subkey_valid, output round_idx, input subkey_ready);
  modport slave  (input subkey, input subkey_valid, input round_idx, output subkey_ready);
endinterface

// File: rtl/des_pc2.sv
// Combinational DES PC-2 permutation: {C,D} (56 bits) -> 48-bit round subkey.
module des_pc2
  import des_pkg::*;
(
  input  logic [55:0] cd,
  output des_subkey_t subkey
);

  always_comb begin
    subkey = '0;
    for (int unsigned i = 0; i < 48; i++) begin
      subkey[6'(47 - i)] = cd[6'(56 - PC2_TABLE[i])];
    end
  end

endmodule

// File: rtl/des_key_schedule.sv
// DES round-subkey generator: PC-1, per-round C/D rotation and PC-2, one subkey per handshake.
// Optional key parity check enabled by defining DES_KEY_PARITY_CHECK_EN.
module des_key_schedule
  import des_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic [63:0]                key,
  input  logic                       encrypt,
  des_key_schedule_if.master         ks,
  output logic                       busy,
  output logic                       done,
  output logic                       parity_err
);

  ks_state_e   state_q, state_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic [3:0]  idx_q, idx_d, idx_inc;
  logic        enc_q, enc_d;
  logic        done_q, done_d;
  logic        key_ok;
  logic        hs;
  logic [55:0] cd_load;

`ifdef DES_KEY_PARITY_CHECK_EN
  logic perr_q;

  assign key_ok = key_parity_ok(key);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       perr_q <= 1'b0;
    else if (load) perr_q <= ~key_ok;
  end

  assign parity_err = perr_q;
`else
  assign key_ok     = 1'b1;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_q    <= '0;
      d_q    <= '0;
      idx_q  <= '0;
      enc_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      c_q    <= c_d;
      d_q    <= d_d;
      idx_q  <= idx_d;
      enc_q  <= enc_d;
      done_q <= done_d;
    end
  end

  // load outranks a same-cycle handshake; decrypt walks C/D backwards since C16 == C0.
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    idx_d   = idx_q;
    enc_d   = enc_q;
    done_d  = 1'b0;
    cd_load = pc1(key);
    idx_inc = idx_q + 4'd1;
    hs      = (state_q == ACTIVE) && ks.subkey_ready;

    if (load) begin
      if (key_ok) begin
        state_d = ACTIVE;
        enc_d   = encrypt;
        idx_d   = '0;
        if (encrypt) begin
          c_d = rotl28(cd_load[55:28], SHIFT_ENC[0]);
          d_d = rotl28(cd_load[27:0],  SHIFT_ENC[0]);
        end else begin
          c_d = rotr28(cd_load[55:28], SHIFT_DEC[0]);
          d_d = rotr28(cd_load[27:0],  SHIFT_DEC[0]);
        end
      end else begin
        state_d = IDLE;
      end
    end else if (hs) begin
      if (idx_q == 4'd15) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        idx_d = idx_inc;
        if (enc_q) begin
          c_d = rotl28(c_q, SHIFT_ENC[idx_inc]);
          d_d = rotl28(d_q, SHIFT_ENC[idx_inc]);
        end else begin
          c_d = rotr28(c_q, SHIFT_DEC[idx_inc]);
          d_d = rotr28(d_q, SHIFT_DEC[idx_inc]);
        end
      end
    end
  end

  des_pc2 u_pc2 (
    .cd     ({c_q, d_q}),
    .subkey (ks.subkey)
  );

  assign ks.subkey_valid = (state_q == ACTIVE);
  assign ks.round_idx    = idx_q;
  assign busy            = (state_q == ACTIVE);
  assign done            = done_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Scoreboard bench for des_key_schedule against the published DES subkeys of key 133457799BBCDFF1.
module tb_des_key_schedule;

  typedef struct {
    logic [47:0] sk;
    logic [3:0]  idx;
  } exp_t;

  localparam logic [63:0] MAIN_KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] BADP_KEY = 64'h133457799BBCDFF0;
  localparam logic [63:0] ONES_KEY = 64'hFEFEFEFEFEFEFEFE;
  localparam logic [47:0] ENC_K [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [63:0] key = '0;
  logic        encrypt = 1'b0;
  logic        busy, done, parity_err;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];

  des_key_schedule_if ks_if ();

  des_key_schedule dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .key        (key),
    .encrypt    (encrypt),
    .ks         (ks_if),
    .busy       (busy),
    .done       (done),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "timeout");
  end

  // kind 0: main key schedule, 1: all-ones subkeys, 2: no subkeys expected
  task automatic do_load(input logic [63:0] k, input bit e, input int kind);
    exp_t x;
    load = 1'b1;
    key = k;
    encrypt = e;
    if (kind != 2) begin
      for (int i = 0; i < 16; i++) begin
        x.idx = 4'(i);
        x.sk  = (kind == 1) ? 48'hFFFFFFFFFFFF : (e ? ENC_K[i] : ENC_K[15 - i]);
        sb.push_back(x);
      end
    end
    @(posedge clk); #1;
    load = 1'b0;
    key = {$urandom, $urandom};
    encrypt = 1'($urandom_range(0, 1));
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    checks++;
    if ({ks_if.subkey_valid, busy, done, parity_err} !== 4'b0000 || ks_if.subkey !== 48'h0 ||
        ks_if.round_idx !== 4'd0) begin
      errors++;
      $display("FAIL reset_init: valid/busy/done/perr=%b subkey=%h idx=%0d, required 0000 0 0",
               {ks_if.subkey_valid, busy, done, parity_err}, ks_if.subkey, ks_if.round_idx);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    ks_if.subkey_ready = 1'b1;
    sb.delete();
    do_load(MAIN_KEY, 1'b1, 0);
    repeat (5) begin @(posedge clk); #1; end
    checks++;
    if (ks_if.round_idx !== 4'd5 || ks_if.subkey !== ENC_K[5]) begin
      errors++;
      $display("FAIL reset_pre_abort: idx=%0d subkey=%h, required 5 %h", ks_if.round_idx, ks_if.subkey, ENC_K[5]);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({ks_if.subkey_valid, busy, done, parity_err} !== 4'b0000 || ks_if.subkey !== 48'h0 ||
        ks_if.round_idx !== 4'd0) begin
      errors++;
      $display("FAIL reset_async: valid/busy/done/perr=%b subkey=%h idx=%0d, required 0000 0 0",
               {ks_if.subkey_valid, busy, done, parity_err}, ks_if.subkey, ks_if.round_idx);
    end
    sb.delete();
    @(negedge clk) rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || ks_if.subkey_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_done: done=%b valid=%b, required 0 0", done, ks_if.subkey_valid);
      end
    end
  endtask

  task automatic test_vectors();
    exp_t x;
    bit   e;
    int   hs, cyc;
    for (int m = 0; m < 2; m++) begin
      e = (m == 0);
      hs = 0;
      cyc = 0;
      sb.delete();
      ks_if.subkey_ready = 1'b1;
      do_load(MAIN_KEY, e, 0);
      while (hs < 16 && cyc < 40) begin
        if (ks_if.subkey_valid === 1'b1 && ks_if.subkey_ready === 1'b1) begin
          x = sb.pop_front();
          checks++;
          if (ks_if.subkey !== x.sk || ks_if.round_idx !== x.idx) begin
            errors++;
            $display("FAIL vec_%s_subkey: got %h idx %0d, required %h idx %0d",
                     e ? "enc" : "dec", ks_if.subkey, ks_if.round_idx, x.sk, x.idx);
          end
          hs++;
        end
        @(posedge clk); #1;
        cyc++;
      end
      checks++;
      if (hs !== 16 || cyc !== 16) begin
        errors++;
        $display("FAIL vec_latency: %0d handshakes in %0d cycles, required 16 in 16", hs, cyc);
      end
      checks++;
      if (done !== 1'b1 || ks_if.subkey_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL vec_done: done=%b valid=%b busy=%b, required 1 0 0", done, ks_if.subkey_valid, busy);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL vec_done_pulse: done=%b one cycle later, required 0", done);
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t        x;
    int          hs = 0, cyc = 0;
    bit          stalled = 1'b0;
    logic [47:0] held_sk = '0;
    logic [3:0]  held_idx = '0;
    sb.delete();
    ks_if.subkey_ready = 1'b0;
    do_load(MAIN_KEY, 1'b0, 0);
    while (hs < 16 && cyc < 400) begin
      if (stalled) begin
        checks++;
        if (ks_if.subkey_valid !== 1'b1 || ks_if.subkey !== held_sk || ks_if.round_idx !== held_idx) begin
          errors++;
          $display("FAIL bp_stall_hold: valid=%b subkey=%h idx=%0d, required 1 %h %0d",
                   ks_if.subkey_valid, ks_if.subkey, ks_if.round_idx, held_sk, held_idx);
        end
      end
      ks_if.subkey_ready = (cyc % 3 == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      stalled = 1'b0;
      if (ks_if.subkey_valid === 1'b1 && ks_if.subkey_ready === 1'b1) begin
        x = sb.pop_front();
        checks++;
        if (ks_if.subkey !== x.sk || ks_if.round_idx !== x.idx) begin
          errors++;
          $display("FAIL bp_subkey: got %h idx %0d, required %h idx %0d",
                   ks_if.subkey, ks_if.round_idx, x.sk, x.idx);
        end
        hs++;
      end else if (ks_if.subkey_valid === 1'b1) begin
        stalled = 1'b1;
        held_sk = ks_if.subkey;
        held_idx = ks_if.round_idx;
      end
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (hs !== 16 || sb.size() !== 0 || done !== 1'b1 || ks_if.subkey_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_complete: hs=%0d left=%0d done=%b valid=%b, required 16 0 1 0",
               hs, sb.size(), done, ks_if.subkey_valid);
    end
    ks_if.subkey_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (ks_if.subkey_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL bp_idle_ready: valid=%b done=%b busy=%b, required 0 0 0", ks_if.subkey_valid, done, busy);
      end
    end
  endtask

  task automatic test_restart();
    exp_t x;
    int   hs = 0, cyc = 0;
    sb.delete();
    ks_if.subkey_ready = 1'b1;
    do_load(ONES_KEY, 1'b1, 1);
    for (int i = 0; i < 7; i++) begin
      x = sb.pop_front();
      checks++;
      if (ks_if.subkey !== x.sk || ks_if.round_idx !== x.idx) begin
        errors++;
        $display("FAIL restart_first: got %h idx %0d, required %h idx %0d", ks_if.subkey, ks_if.round_idx, x.sk, x.idx);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (ks_if.round_idx !== 4'd7 || ks_if.subkey_valid !== 1'b1) begin
      errors++;
      $display("FAIL restart_at7: idx=%0d valid=%b, required 7 1", ks_if.round_idx, ks_if.subkey_valid);
    end
    sb.delete();
    do_load(MAIN_KEY, 1'b1, 0);
    while (hs < 16 && cyc < 40) begin
      x = sb.pop_front();
      checks++;
      if (ks_if.subkey_valid !== 1'b1 || ks_if.subkey !== x.sk || ks_if.round_idx !== x.idx) begin
        errors++;
        $display("FAIL restart_subkey: valid=%b got %h idx %0d, required 1 %h idx %0d",
                 ks_if.subkey_valid, ks_if.subkey, ks_if.round_idx, x.sk, x.idx);
      end
      hs++;
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (done !== 1'b1 || ks_if.subkey_valid !== 1'b0) begin
      errors++;
      $display("FAIL restart_done: done=%b valid=%b, required 1 0", done, ks_if.subkey_valid);
    end
  endtask

  task automatic test_parity();
    exp_t x;
    int   hs = 0, cyc = 0;
    sb.delete();
    ks_if.subkey_ready = 1'b1;
    @(posedge clk); #1;
`ifdef DES_KEY_PARITY_CHECK_EN
    do_load(BADP_KEY, 1'b1, 2);
    repeat (3) begin
      checks++;
      if (parity_err !== 1'b1 || ks_if.subkey_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL parity_reject: perr=%b valid=%b busy=%b, required 1 0 0", parity_err, ks_if.subkey_valid, busy);
      end
      @(posedge clk); #1;
    end
    do_load(MAIN_KEY, 1'b1, 0);
`else
    do_load(BADP_KEY, 1'b1, 0);
`endif
    while (hs < 16 && cyc < 40) begin
      if (ks_if.subkey_valid === 1'b1) begin
        x = sb.pop_front();
        checks++;
        if (parity_err !== 1'b0 || ks_if.subkey !== x.sk || ks_if.round_idx !== x.idx) begin
          errors++;
          $display("FAIL parity_run: perr=%b got %h idx %0d, required 0 %h idx %0d",
                   parity_err, ks_if.subkey, ks_if.round_idx, x.sk, x.idx);
        end
        hs++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (hs !== 16 || done !== 1'b1) begin
      errors++;
      $display("FAIL parity_done: hs=%0d done=%b, required 16 1", hs, done);
    end
  endtask

  initial begin
    ks_if.subkey_ready = 1'b0;
    test_reset();
    test_vectors();
    test_backpressure();
    test_restart();
    test_parity();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
